// File: rtl/kfps2kb_scancode_queue_if.sv
// Bus bundle between the PS/2 receiver / CPU port logic and the scancode queue.
// master drives received bytes, lookup results and pops; slave is the queue.
interface kfps2kb_scancode_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          enable;
  logic          flush;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_error;
  logic [7:0]    xlat_code;
  logic [7:0]    xlat_result;
  logic          irq;
  logic [7:0]    keycode;
  logic          clear_keycode;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output enable, flush, rx_valid, rx_data, rx_error, xlat_result, clear_keycode,
    input  xlat_code, irq, keycode, count, overflow
  );

  modport slave (
    input  enable, flush, rx_valid, rx_data, rx_error, xlat_result, clear_keycode,
    output xlat_code, irq, keycode, count, overflow
  );
endinterface

// File: rtl/kfps2kb_scancode_queue.sv
// PS/2 set-2 front end: prefix tracking, optional set-1 translation and a
// scancode FIFO presented to the CPU one code per clear_keycode pop.
module kfps2kb_scancode_queue #(
  parameter int DEPTH = 16,
  parameter int XLAT  = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  kfps2kb_scancode_queue_if.slave        bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, PRE, BRK, PREBRK, EMIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    lat_q, lat_nxt;
  logic          wr_req;
  logic [7:0]    wr_val;
  logic          brk;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          ovf_q;
  logic          push, pop, set_ovf;
  logic [7:0]    push_val;

  assign brk = (state == BRK) || (state == PREBRK);

  // Decoder: at most one FIFO write request per edge (strobes are ignored in EMIT).
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_q;
    wr_req    = 1'b0;
    wr_val    = 8'h00;
    if (state == EMIT) begin
      wr_req    = 1'b1;
      wr_val    = lat_q;
      state_nxt = IDLE;
    end else if (bus.rx_error) begin
      wr_req    = 1'b1;
      wr_val    = 8'hFF;
      state_nxt = IDLE;
    end else if (bus.rx_valid) begin
      if (XLAT == 0) begin
        wr_req = (bus.rx_data != 8'hFA);
        wr_val = bus.rx_data;
      end else begin
        case (bus.rx_data)
          8'hFA, 8'hEE: ;
          8'h00, 8'hFF: begin
            wr_req    = 1'b1;
            wr_val    = 8'hFF;
            state_nxt = IDLE;
          end
          8'hAA: begin
            wr_req    = 1'b1;
            wr_val    = 8'hAA;
            state_nxt = IDLE;
          end
          8'hE1: begin
            wr_req = 1'b1;
            wr_val = 8'hE1;
          end
          8'hE0: begin
            if (state == IDLE)     state_nxt = PRE;
            else if (state == BRK) state_nxt = PREBRK;
          end
          8'hF0: begin
            if (state == IDLE)     state_nxt = BRK;
            else if (state == PRE) state_nxt = PREBRK;
          end
          default: begin
            state_nxt = IDLE;
            if (state == IDLE || state == BRK) begin
              wr_req = 1'b1;
              wr_val = bus.xlat_result | (brk ? 8'h80 : 8'h00);
            end else if (bus.rx_data != 8'h12 && bus.rx_data != 8'h59) begin
              // Extended key: E0 now, translated code on the EMIT edge.
              wr_req    = 1'b1;
              wr_val    = 8'hE0;
              lat_nxt   = bus.xlat_result | (brk ? 8'h80 : 8'h00);
              state_nxt = EMIT;
            end
          end
        endcase
      end
    end
  end

  // Last free slot takes an FF overrun marker; everything after is dropped until drained.
  always_comb begin
    push     = 1'b0;
    set_ovf  = 1'b0;
    push_val = wr_val;
    if (wr_req && !ovf_q) begin
      if (count_q < CW'(DEPTH - 1)) begin
        push = 1'b1;
      end else if (count_q == CW'(DEPTH - 1)) begin
        push     = 1'b1;
        push_val = 8'hFF;
        set_ovf  = 1'b1;
      end
    end
    pop = bus.clear_keycode && (count_q != '0);
    count_nxt = count_q;
    if (push && !pop)      count_nxt = count_q + CW'(1);
    else if (!push && pop) count_nxt = count_q - CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_q   <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      state   <= IDLE;
      lat_q   <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_q   <= lat_nxt;
      count_q <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (set_ovf)                ovf_q <= 1'b1;
      else if (count_nxt == '0)   ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !bus.flush) mem[wr_ptr] <= push_val;
  end

  assign bus.xlat_code = bus.rx_data;
  assign bus.keycode   = (count_q != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.irq       = bus.enable && (count_q != '0);
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_kfps2kb_scancode_queue.sv
// Bench: three queue variants (16/xlat, 4/xlat, 16/raw) driven through a shared
// stimulus mux; expected codes go through a scoreboard queue checked on each pop.
module tb_kfps2kb_scancode_queue;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  kfps2kb_scancode_queue_if #(.DEPTH(16)) if0 ();
  kfps2kb_scancode_queue_if #(.DEPTH(4))  if1 ();
  kfps2kb_scancode_queue_if #(.DEPTH(16)) if2 ();

  kfps2kb_scancode_queue #(.DEPTH(16), .XLAT(1)) u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
  kfps2kb_scancode_queue #(.DEPTH(4),  .XLAT(1)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));
  kfps2kb_scancode_queue #(.DEPTH(16), .XLAT(0)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2));

  // External set-2 -> set-1 lookup (subset used by the bench).
  function automatic logic [7:0] xlat_f(input logic [7:0] c);
    case (c)
      8'h1C:   return 8'h1E;
      8'h75:   return 8'h48;
      8'h12:   return 8'h2A;
      8'h59:   return 8'h36;
      default: return c ^ 8'h55;
    endcase
  endfunction

  int         sel = 0;
  logic       en = 1'b1, d_valid = 1'b0, d_err = 1'b0, d_clr = 1'b0, d_flush = 1'b0;
  logic [7:0] d_data = 8'h00;

  always_comb begin
    if0.enable = en; if0.rx_data = d_data; if0.xlat_result = xlat_f(if0.xlat_code);
    if0.rx_valid = d_valid && sel == 0; if0.rx_error = d_err && sel == 0;
    if0.clear_keycode = d_clr && sel == 0; if0.flush = d_flush && sel == 0;
  end
  always_comb begin
    if1.enable = en; if1.rx_data = d_data; if1.xlat_result = xlat_f(if1.xlat_code);
    if1.rx_valid = d_valid && sel == 1; if1.rx_error = d_err && sel == 1;
    if1.clear_keycode = d_clr && sel == 1; if1.flush = d_flush && sel == 1;
  end
  always_comb begin
    if2.enable = en; if2.rx_data = d_data; if2.xlat_result = xlat_f(if2.xlat_code);
    if2.rx_valid = d_valid && sel == 2; if2.rx_error = d_err && sel == 2;
    if2.clear_keycode = d_clr && sel == 2; if2.flush = d_flush && sel == 2;
  end

  int         cnt_m;
  logic [7:0] key_m;
  logic       irq_m, ovf_m;
  always_comb begin
    case (sel)
      1:       begin cnt_m = int'(if1.count); key_m = if1.keycode; irq_m = if1.irq; ovf_m = if1.overflow; end
      2:       begin cnt_m = int'(if2.count); key_m = if2.keycode; irq_m = if2.irq; ovf_m = if2.overflow; end
      default: begin cnt_m = int'(if0.count); key_m = if0.keycode; irq_m = if0.irq; ovf_m = if0.overflow; end
    endcase
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [7:0] b);
    d_data = b; d_valid = 1'b1; tick(); d_valid = 1'b0; tick();
  endtask

  task automatic err_pulse;
    d_err = 1'b1; tick(); d_err = 1'b0; tick();
  endtask

  task automatic check_status(input string tag);
    check({tag, " count"}, cnt_m, exp_q.size());
    check({tag, " irq"}, int'(irq_m), int'(en && exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, " head"}, int'(key_m), int'(exp_q[0]));
    else                   check({tag, " head empty"}, int'(key_m), 0);
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() != 0) check({tag, " pop head"}, int'(key_m), int'(exp_q[0]));
    d_clr = 1'b1; tick(); d_clr = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check({tag, " pop count"}, cnt_m, exp_q.size());
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " count"}, cnt_m, 0);
    check({tag, " key"}, int'(key_m), 0);
    check({tag, " irq"}, int'(irq_m), 0);
    check({tag, " ovf"}, int'(ovf_m), 0);
  endtask

  typedef struct {
    logic [7:0] rx;
    bit         err;
    int         n;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t vt[$];

  initial begin
    vt.push_back('{8'hFA, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'hE0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h12, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'hE0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'hF0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h59, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h1C, 1'b0, 1, 8'h1E, 8'h00});
    vt.push_back('{8'hF0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h1C, 1'b0, 1, 8'h9E, 8'h00});
    vt.push_back('{8'hE0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h75, 1'b0, 2, 8'hE0, 8'h48});
    vt.push_back('{8'hE0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'hF0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h75, 1'b0, 2, 8'hE0, 8'hC8});
    vt.push_back('{8'h00, 1'b0, 1, 8'hFF, 8'h00});
    vt.push_back('{8'hF0, 1'b0, 0, 8'h00, 8'h00});
    vt.push_back('{8'h00, 1'b1, 1, 8'hFF, 8'h00});
    vt.push_back('{8'h1C, 1'b0, 1, 8'h1E, 8'h00});
    vt.push_back('{8'hAA, 1'b0, 1, 8'hAA, 8'h00});
    vt.push_back('{8'hE1, 1'b0, 1, 8'hE1, 8'h00});
    vt.push_back('{8'hEE, 1'b0, 0, 8'h00, 8'h00});

    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check_reset_vals($sformatf("reset dut%0d", i));
    end
    reset_n = 1'b1;
    sel = 0;
    tick();

    // Table: translation, prefixes, filtering, error handling.
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].err) err_pulse(); else send(vt[i].rx);
      if (vt[i].n > 0) exp_q.push_back(vt[i].e0);
      if (vt[i].n > 1) exp_q.push_back(vt[i].e1);
      check_status($sformatf("vec%0d", i));
    end
    while (exp_q.size() != 0) pop_chk("drain0");
    check_status("drained0");

    // Pop and push on the same edge keep count.
    send(8'h1C); exp_q.push_back(8'h1E);
    send(8'h1C); exp_q.push_back(8'h1E);
    d_data = 8'h1C; d_valid = 1'b1; d_clr = 1'b1; tick();
    d_valid = 1'b0; d_clr = 1'b0; tick();
    void'(exp_q.pop_front()); exp_q.push_back(8'h1E);
    check_status("push+pop");

    // Flush beats a simultaneous byte.
    d_flush = 1'b1; d_data = 8'h1C; d_valid = 1'b1; tick();
    d_flush = 1'b0; d_valid = 1'b0; tick();
    exp_q.delete();
    check_status("flush");
    check("flush ovf", int'(ovf_m), 0);

    // Reset while EMIT is pending drops the latched code.
    send(8'hE0);
    d_data = 8'h75; d_valid = 1'b1; tick(); d_valid = 1'b0;
    check("emit pending count", cnt_m, 1);
    #2 reset_n = 1'b0; #1;
    check_reset_vals("reset in EMIT");
    tick(); reset_n = 1'b1; tick();
    exp_q.delete();
    check_status("after reset");
    send(8'h1C); exp_q.push_back(8'h1E);
    check_status("fsm idle after reset");
    while (exp_q.size() != 0) pop_chk("drain1");

    // Overflow on the 4-deep variant.
    sel = 1; #1;
    for (int i = 0; i < 5; i++) begin
      send(8'h1C);
      if (i < 3) exp_q.push_back(8'h1E);
      else if (i == 3) exp_q.push_back(8'hFF);
      check_status($sformatf("ovf push%0d", i));
      check($sformatf("ovf flag push%0d", i), int'(ovf_m), int'(i >= 3));
    end
    for (int i = 0; i < 4; i++) begin
      pop_chk($sformatf("ovf pop%0d", i));
      check($sformatf("ovf flag pop%0d", i), int'(ovf_m), int'(i < 3));
    end

    // Raw pass-through variant.
    sel = 2; #1;
    send(8'hF0); exp_q.push_back(8'hF0);
    send(8'h1C); exp_q.push_back(8'h1C);
    send(8'hFA);
    check_status("raw");
    en = 1'b0; #1;
    check("raw irq disabled", int'(irq_m), 0);
    check("raw count disabled", cnt_m, 2);
    en = 1'b1; #1;
    check("raw irq enabled", int'(irq_m), 1);
    #2 reset_n = 1'b0; #1;
    check_reset_vals("raw async reset");
    exp_q.delete();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
